// File: rtl/sr_flag_bank_pkg.sv
// Shared constants and the per-channel priority decode for the sr_flag_bank family.
package sr_flag_bank_pkg;

  localparam int SR_RST_DOM = 0;
  localparam int SR_SET_DOM = 1;
  localparam int SR_LEVEL   = 0;
  localparam int SR_EDGE    = 1;
  localparam int SR_MAX_CH  = 32;

  typedef enum logic [1:0] {
    SR_HOLD,
    SR_SET,
    SR_CLR_Q,
    SR_WIPE
  } sr_action_e;

  // Software clear outranks everything; dominance only matters when set and reset coincide.
  function automatic sr_action_e sr_decide(input logic clr, input logic se, input logic re,
                                           input bit set_dom);
    if (clr) return SR_WIPE;
    if (se && re) return set_dom ? SR_SET : SR_CLR_Q;
    if (se) return SR_SET;
    if (re) return SR_CLR_Q;
    return SR_HOLD;
  endfunction

endpackage

// File: rtl/sr_flag_bank_cell.sv
// One set/reset flag channel: optional edge detection, flag, sticky overrun.
module sr_cell
  import sr_flag_bank_pkg::*;
#(
  parameter int EDGE    = SR_LEVEL,
  parameter int SET_DOM = SR_RST_DOM
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  input  logic clr,
  output logic q,
  output logic ovr
);

  logic       s_prev;
  logic       r_prev;
  logic       se;
  logic       re;
  sr_action_e action;

  assign se = (EDGE != 0) ? (s & ~s_prev) : s;
  assign re = (EDGE != 0) ? (r & ~r_prev) : r;

  always_comb begin
    action = sr_decide(clr, se, re, SET_DOM != 0);
  end

  // History always tracks the inputs, so a level held through reset yields no edge afterwards.
  always_ff @(posedge clk) begin
    s_prev <= s;
    r_prev <= r;
    if (rst) begin
      q   <= 1'b0;
      ovr <= 1'b0;
    end else begin
      case (action)
        SR_WIPE: begin
          q   <= 1'b0;
          ovr <= 1'b0;
        end
        SR_SET:   q <= 1'b1;
        SR_CLR_Q: q <= 1'b0;
        default:  q <= q;
      endcase
      // A set arriving on an already-set flag is lost, even if reset wins this cycle.
      if (se && q && !clr) ovr <= 1'b1;
    end
  end

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of N independent set/reset flags with a maskable registered interrupt.
module sr_flag_bank
  import sr_flag_bank_pkg::*;
#(
  parameter int           N        = 8,
  parameter int           EDGE     = SR_LEVEL,
  parameter int           SET_DOM  = SR_RST_DOM,
  parameter logic [N-1:0] MASK_RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] s,
  input  logic [N-1:0] r,
  input  logic [N-1:0] clr,
  input  logic         mask_wr,
  input  logic [N-1:0] mask_wdata,
  output logic [N-1:0] q,
  output logic [N-1:0] ovr,
  output logic [N-1:0] mask,
  output logic         irq
);

  for (genvar i = 0; i < N; i++) begin : g_cell
    sr_cell #(
      .EDGE    (EDGE),
      .SET_DOM (SET_DOM)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .s   (s[i]),
      .r   (r[i]),
      .clr (clr[i]),
      .q   (q[i]),
      .ovr (ovr[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= MASK_RST;
    end else if (mask_wr) begin
      mask <= mask_wdata;
    end
  end

  // Built from the registered q and mask, so it trails a flag change by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |(q & mask);
    end
  end

endmodule

// File: tb/tb_sr_flag_bank.sv
// Scoreboard bench: five sr_flag_bank configurations driven from one shared stimulus stream.
module tb_sr_flag_bank;

  typedef struct {
    int          inst;
    logic [31:0] q;
    logic [31:0] ovr;
    logic [31:0] mask;
    logic        irq;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] s_bus;
  logic [31:0] r_bus;
  logic [31:0] clr_bus;
  logic        mask_wr;
  logic [31:0] mwd_bus;

  logic [7:0]  q0, ovr0, mask0, q1, ovr1, mask1, q2, ovr2, mask2;
  logic [31:0] q3, ovr3, mask3;
  logic [0:0]  q4, ovr4, mask4;
  logic        irq0, irq1, irq2, irq3, irq4;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  int          cfg_n    [5] = '{8, 8, 8, 32, 1};
  bit          cfg_edge [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  bit          cfg_sdom [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] cfg_mrst [5] = '{32'h0F, 32'h0F, 32'h0F, 32'hF00F_000F, 32'h1};

  logic [31:0] m_q[5], m_ovr[5], m_mask[5], m_sp[5], m_rp[5];
  logic        m_irq[5];

  sr_flag_bank #(.N(8), .EDGE(0), .SET_DOM(0), .MASK_RST(8'h0F)) dut0 (
    .clk(clk), .rst(rst), .s(s_bus[7:0]), .r(r_bus[7:0]), .clr(clr_bus[7:0]),
    .mask_wr(mask_wr), .mask_wdata(mwd_bus[7:0]), .q(q0), .ovr(ovr0), .mask(mask0), .irq(irq0));
  sr_flag_bank #(.N(8), .EDGE(0), .SET_DOM(1), .MASK_RST(8'h0F)) dut1 (
    .clk(clk), .rst(rst), .s(s_bus[7:0]), .r(r_bus[7:0]), .clr(clr_bus[7:0]),
    .mask_wr(mask_wr), .mask_wdata(mwd_bus[7:0]), .q(q1), .ovr(ovr1), .mask(mask1), .irq(irq1));
  sr_flag_bank #(.N(8), .EDGE(1), .SET_DOM(0), .MASK_RST(8'h0F)) dut2 (
    .clk(clk), .rst(rst), .s(s_bus[7:0]), .r(r_bus[7:0]), .clr(clr_bus[7:0]),
    .mask_wr(mask_wr), .mask_wdata(mwd_bus[7:0]), .q(q2), .ovr(ovr2), .mask(mask2), .irq(irq2));
  sr_flag_bank #(.N(32), .EDGE(1), .SET_DOM(1), .MASK_RST(32'hF00F_000F)) dut3 (
    .clk(clk), .rst(rst), .s(s_bus), .r(r_bus), .clr(clr_bus),
    .mask_wr(mask_wr), .mask_wdata(mwd_bus), .q(q3), .ovr(ovr3), .mask(mask3), .irq(irq3));
  sr_flag_bank #(.N(1), .EDGE(0), .SET_DOM(0), .MASK_RST(1'b1)) dut4 (
    .clk(clk), .rst(rst), .s(s_bus[0:0]), .r(r_bus[0:0]), .clr(clr_bus[0:0]),
    .mask_wr(mask_wr), .mask_wdata(mwd_bus[0:0]), .q(q4), .ovr(ovr4), .mask(mask4), .irq(irq4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] width_mask(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
  endfunction

  function automatic exp_t actual_of(input int inst);
    exp_t a;
    case (inst)
      0:       a = '{0, {24'b0, q0}, {24'b0, ovr0}, {24'b0, mask0}, irq0};
      1:       a = '{1, {24'b0, q1}, {24'b0, ovr1}, {24'b0, mask1}, irq1};
      2:       a = '{2, {24'b0, q2}, {24'b0, ovr2}, {24'b0, mask2}, irq2};
      3:       a = '{3, q3, ovr3, mask3, irq3};
      default: a = '{4, {31'b0, q4}, {31'b0, ovr4}, {31'b0, mask4}, irq4};
    endcase
    return a;
  endfunction

  task automatic compareVal(input string tag, input int inst, input logic [31:0] act,
                            input logic [31:0] exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else $error("[TB] FAIL %s inst%0d: observed %h expected %h", tag, inst, act, exp);
  endtask

  // Pops every expectation queued for the edge just taken.
  task automatic checkOutput(input string tag);
    exp_t e;
    exp_t a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = actual_of(e.inst);
      compareVal({tag, ".q"},    e.inst, a.q,    e.q);
      compareVal({tag, ".ovr"},  e.inst, a.ovr,  e.ovr);
      compareVal({tag, ".mask"}, e.inst, a.mask, e.mask);
      compareVal({tag, ".irq"},  e.inst, {31'b0, a.irq}, {31'b0, e.irq});
    end
  endtask

  // Drives one cycle, advances the reference model, then checks after the edge.
  task automatic applyStimulus(input string tag, input logic [31:0] s_v, input logic [31:0] r_v,
                               input logic [31:0] c_v, input logic mw, input logic [31:0] wd,
                               input logic rst_v);
    @(negedge clk);
    s_bus = s_v; r_bus = r_v; clr_bus = c_v; mask_wr = mw; mwd_bus = wd; rst = rst_v;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] wm, sv, rv, cv, se, re, both, qn, on;
      wm = width_mask(cfg_n[i]);
      sv = s_v & wm; rv = r_v & wm; cv = c_v & wm;
      if (rst_v) begin
        m_q[i] = '0; m_ovr[i] = '0; m_irq[i] = 1'b0; m_mask[i] = cfg_mrst[i] & wm;
      end else begin
        se   = cfg_edge[i] ? (sv & ~m_sp[i]) : sv;
        re   = cfg_edge[i] ? (rv & ~m_rp[i]) : rv;
        both = se & re;
        qn   = ~cv & ((both & {32{cfg_sdom[i]}}) | (se & ~re) | (m_q[i] & ~se & ~re));
        on   = (m_ovr[i] | (se & m_q[i])) & ~cv;
        m_irq[i]  = |(m_q[i] & m_mask[i]);
        m_mask[i] = mw ? (wd & wm) : m_mask[i];
        m_q[i]    = qn;
        m_ovr[i]  = on;
      end
      m_sp[i] = sv;
      m_rp[i] = rv;
      sb.push_back('{i, m_q[i], m_ovr[i], m_mask[i], m_irq[i]});
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wipe(input string tag);
    applyStimulus(tag, '0, '0, '1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [31:0] rs, rr, rc, rw;
    logic        rmw, rrst;
    s_bus = '0; r_bus = '0; clr_bus = '0; mask_wr = 1'b0; mwd_bus = '0; rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_q[i] = '0; m_ovr[i] = '0; m_mask[i] = '0; m_sp[i] = '0; m_rp[i] = '0; m_irq[i] = 1'b0;
    end

    // Reset with s high; edge-mode channels must not see an edge on release.
    applyStimulus("rst", 32'hFF, '0, '0, 1'b0, '0, 1'b1);
    applyStimulus("rst", 32'hFF, '0, '0, 1'b0, '0, 1'b1);
    compareVal("rst_q0", 0, {24'b0, q0}, 32'h0);
    compareVal("rst_ovr0", 0, {24'b0, ovr0}, 32'h0);
    compareVal("rst_irq0", 0, {31'b0, irq0}, 32'h0);
    compareVal("rst_mask0", 0, {24'b0, mask0}, 32'h0F);
    applyStimulus("release", 32'hFF, '0, '0, 1'b0, '0, 1'b0);
    compareVal("edge_no_set_q2", 2, {24'b0, q2}, 32'h0);
    applyStimulus("release", 32'hFF, '0, '0, 1'b0, '0, 1'b0);
    compareVal("edge_no_set_q3", 3, q3, 32'h0);
    wipe("wipe1");

    // Level set/reset latency and irq lag.
    applyStimulus("set3", 32'h08, '0, '0, 1'b0, '0, 1'b0);
    compareVal("set3_q0", 0, {24'b0, q0}, 32'h08);
    idle("set3_idle");
    compareVal("set3_irq0", 0, {31'b0, irq0}, 32'h1);
    applyStimulus("rst3", '0, 32'h08, '0, 1'b0, '0, 1'b0);
    compareVal("rst3_q0", 0, {24'b0, q0}, 32'h0);
    idle("rst3_idle");
    compareVal("rst3_irq0", 0, {31'b0, irq0}, 32'h0);

    // Dominance, then s/r held: edge mode sets once, level set-dominant overruns.
    applyStimulus("dom", 32'h01, 32'h01, '0, 1'b0, '0, 1'b0);
    compareVal("dom_q0", 0, {24'b0, q0}, 32'h0);
    compareVal("dom_q1", 1, {24'b0, q1}, 32'h1);
    wipe("wipe2");
    for (int k = 0; k < 4; k++) applyStimulus("hold", 32'h01, 32'h01, '0, 1'b0, '0, 1'b0);
    compareVal("hold_q3", 3, q3, 32'h1);
    compareVal("hold_ovr3", 3, ovr3, 32'h0);
    compareVal("hold_ovr1", 1, {24'b0, ovr1}, 32'h1);
    wipe("wipe3");

    // Overrun stickiness and clear priority.
    applyStimulus("ovr_set", 32'h20, '0, '0, 1'b0, '0, 1'b0);
    idle("ovr_idle");
    applyStimulus("ovr_again", 32'h20, '0, '0, 1'b0, '0, 1'b0);
    compareVal("ovr_ovr0", 0, {24'b0, ovr0}, 32'h20);
    compareVal("ovr_q0", 0, {24'b0, q0}, 32'h20);
    applyStimulus("ovr_r", '0, 32'h20, '0, 1'b0, '0, 1'b0);
    compareVal("ovr_r_q0", 0, {24'b0, q0}, 32'h0);
    compareVal("ovr_r_ovr0", 0, {24'b0, ovr0}, 32'h20);
    applyStimulus("ovr_clr", 32'h20, '0, 32'h20, 1'b0, '0, 1'b0);
    compareVal("ovr_clr_q0", 0, {24'b0, q0}, 32'h0);
    compareVal("ovr_clr_ovr0", 0, {24'b0, ovr0}, 32'h0);

    // Mask timing; clr and mask write share the first edge.
    applyStimulus("mask_clr", '0, '0, '1, 1'b1, 32'h0, 1'b0);
    applyStimulus("mask_s81", 32'h81, '0, '0, 1'b0, '0, 1'b0);
    compareVal("mask_q0", 0, {24'b0, q0}, 32'h81);
    idle("mask_idle");
    compareVal("mask0_irq0", 0, {31'b0, irq0}, 32'h0);
    applyStimulus("mask_w80", '0, '0, '0, 1'b1, 32'h80, 1'b0);
    idle("mask_idle80");
    compareVal("mask80_irq0", 0, {31'b0, irq0}, 32'h1);
    applyStimulus("mask_w00", '0, '0, '0, 1'b1, 32'h0, 1'b0);
    idle("mask_idle00");
    compareVal("mask00_irq0", 0, {31'b0, irq0}, 32'h0);

    // Random regression with occasional mid-activity reset and held inputs.
    rs = '0; rr = '0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 1) == 0) rs = $urandom & $urandom;
      if ($urandom_range(0, 1) == 0) rr = $urandom & $urandom;
      rc   = $urandom & $urandom & $urandom & $urandom;
      rmw  = ($urandom_range(0, 7) == 0);
      rw   = $urandom;
      rrst = ($urandom_range(0, 49) == 0);
      applyStimulus("rand", rs, rr, rc, rmw, rw, rrst);
    end

    compareVal("sb_empty", -1, sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
